// File: rtl/spi_word_pkg.sv
// spi_word_pkg: shared types and constants for the SPI word engine.
//   - spi_state_e    : engine state encoding (IDLE, SETUP, XFER, HOLD, GAP)
//   - SPI_DATA_W     : default bits per SPI word
//   - SPI_HALF_DIV   : default bus_clk cycles per SCLK half-period
//   - half_cnt_width : width of the half-period down-counter (holds HALF_DIV-1)
//   - bit_cnt_width  : width of the SCLK toggle counter (holds 2*DATA_W-1)
package spi_word_pkg;

    localparam int SPI_DATA_W   = 16;
    localparam int SPI_HALF_DIV = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // The counter only ever holds 0..HALF_DIV-1; keep at least one bit.
    function automatic int half_cnt_width(input int half_div);
        return (half_div > 2) ? $clog2(half_div) : 1;
    endfunction

    // One count per SCLK toggle, 2*DATA_W toggles per word.
    function automatic int bit_cnt_width(input int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/spi_word_engine_if.sv
// spi_word_engine_if: host stream handshake plus SPI pin bundle.
//   Host write stream : tx_wren, tx_data -> tx_full, tx_drop
//   Host read stream  : rx_rden -> rx_data, rx_empty, rx_overrun
//   Status            : busy
//   SPI pins          : spi_cs_n, spi_sclk, spi_mosi (engine out), spi_miso (engine in)
// modport master : host / pin-side environment driving the engine.
// modport slave  : the engine itself.
interface spi_word_engine_if #(
    parameter int DATA_W = 16
);
    logic              tx_wren;
    logic [DATA_W-1:0] tx_data;
    logic              tx_full;
    logic              rx_rden;
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic              rx_overrun;
    logic              tx_drop;
    logic              busy;
    logic              spi_cs_n;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (
        output tx_wren, tx_data, rx_rden, spi_miso,
        input  tx_full, rx_data, rx_empty, rx_overrun, tx_drop, busy,
               spi_cs_n, spi_sclk, spi_mosi
    );

    modport slave (
        input  tx_wren, tx_data, rx_rden, spi_miso,
        output tx_full, rx_data, rx_empty, rx_overrun, tx_drop, busy,
               spi_cs_n, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_half_tick.sv
// spi_half_tick: loadable down-counter that emits a one-cycle registered
// pulse every HALF_DIV cycles. A restart reloads the count so the first
// pulse after a state change lands exactly HALF_DIV cycles later.
//   clk     : bus clock
//   srst    : synchronous active-high reset (count cleared)
//   restart : reload the counter this edge
//   tick    : one-cycle expiry pulse
module spi_half_tick
    import spi_word_pkg::*;
#(
    parameter int HALF_DIV = SPI_HALF_DIV,
    parameter int CNT_W    = half_cnt_width(HALF_DIV)
) (
    input  logic clk,
    input  logic srst,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count: reload on restart or expiry, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (cnt_q == ZERO) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - ONE;
        end
        // Registering the zero-detect of the next count keeps tick aligned
        // with cnt_q == 0 while still coming straight from a flop.
        tick_d = (cnt_d == ZERO);
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q  <= ZERO;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/spi_word_engine.sv
// spi_word_engine: full-duplex SPI mode-0 master for DATA_W-bit words.
// A word written on the host write stream is parked in a holding register,
// shifted out MSB-first on MOSI while MISO is captured, and the received word
// is presented on a first-word-fall-through read stream.
//   bus_clk : sole clock
//   srst    : synchronous active-high reset, aborts any transfer
//   bus     : spi_word_engine_if.slave (host streams, status, SPI pins)
// Frame timing, each phase HALF_DIV cycles: SETUP (CS low, SCLK low),
// 2*DATA_W SCLK half-periods in XFER, HOLD (CS still low), GAP (CS high).
module spi_word_engine
    import spi_word_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int HALF_DIV = SPI_HALF_DIV
) (
    input  logic             bus_clk,
    input  logic             srst,
    spi_word_engine_if.slave bus
);

    localparam int HALF_W = half_cnt_width(HALF_DIV);
    localparam int BIT_W  = bit_cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] LAST_TOGGLE = BIT_W'(2 * DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO    = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_full_q, tx_full_d;
    logic              rx_empty_q, rx_empty_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_drop_q, tx_drop_d;
    logic              busy_q, busy_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;

    logic tick_s;
    logic restart_s;
    logic tx_drain_s;
    logic tx_accept_s;
    logic rx_wr_s;

    // Any state change restarts the half-period timer.
    assign restart_s = (state_d != state_q);

    spi_half_tick #(
        .HALF_DIV (HALF_DIV),
        .CNT_W    (HALF_W)
    ) u_half_tick (
        .clk     (bus_clk),
        .srst    (srst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Holding register handshake. Leaving IDLE empties the holding register
    // on the same edge, so a write in that cycle still finds room.
    always_comb begin
        tx_drain_s  = (state_q == IDLE) && tx_full_q;
        tx_accept_s = bus.tx_wren && (!tx_full_q || tx_drain_s);
        if (tx_accept_s) begin
            hold_d    = bus.tx_data;
            tx_full_d = 1'b1;
        end else if (tx_drain_s) begin
            hold_d    = hold_q;
            tx_full_d = 1'b0;
        end else begin
            hold_d    = hold_q;
            tx_full_d = tx_full_q;
        end
        tx_drop_d = tx_drop_q | (bus.tx_wren & ~tx_accept_s);
    end

    // Frame sequencer and shift registers.
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_wr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d    = 1'b0;
                bit_cnt_d = BIT_ZERO;
                if (tx_full_q) begin
                    state_d = SETUP;
                    tx_sh_d = hold_q;
                    cs_n_d  = 1'b0;
                    mosi_d  = hold_q[DATA_W-1];
                end else begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_d = XFER;
                end else begin
                    state_d = SETUP;
                end
            end
            XFER: begin
                if (tick_s) begin
                    sclk_d    = ~sclk_q;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (!sclk_q) begin
                        // Rising SCLK: capture MISO.
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.spi_miso};
                    end else begin
                        // Falling SCLK: present the next bit.
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end
                    if (bit_cnt_q == LAST_TOGGLE) begin
                        state_d   = HOLD;
                        bit_cnt_d = BIT_ZERO;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    rx_wr_s = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                mosi_d = 1'b0;
                if (tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Receive register: a read in the same cycle as a new word consumes the
    // old one, so only an unread overwrite counts as overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_empty_d   = rx_empty_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_wr_s) begin
            rx_data_d  = rx_sh_q;
            rx_empty_d = 1'b0;
            if (!rx_empty_q && !bus.rx_rden) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_overrun_d = rx_overrun_q;
            end
        end else if (bus.rx_rden && !rx_empty_q) begin
            rx_empty_d = 1'b1;
        end else begin
            rx_empty_d = rx_empty_q;
        end
    end

    // All engine state and registered outputs.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_q      <= IDLE;
            hold_q       <= {DATA_W{1'b0}};
            tx_sh_q      <= {DATA_W{1'b0}};
            rx_sh_q      <= {DATA_W{1'b0}};
            rx_data_q    <= {DATA_W{1'b0}};
            bit_cnt_q    <= BIT_ZERO;
            tx_full_q    <= 1'b0;
            rx_empty_q   <= 1'b1;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
            busy_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            tx_sh_q      <= tx_sh_d;
            rx_sh_q      <= rx_sh_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_full_q    <= tx_full_d;
            rx_empty_q   <= rx_empty_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
            busy_q       <= busy_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
        end
    end

    assign bus.tx_full    = tx_full_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_empty   = rx_empty_q;
    assign bus.rx_overrun = rx_overrun_q;
    assign bus.tx_drop    = tx_drop_q;
    assign bus.busy       = busy_q;
    assign bus.spi_cs_n   = cs_n_q;
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_mosi   = mosi_q;

endmodule
